// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake plus the operand/opcode bus driven into the 8-bit ALU.
interface alu_op_sequencer_if #(
   parameter int DATA_W   = 8,
   parameter int OPCODE_W = 16
);
   logic                instr_valid;
   logic                instr_ready;
   logic [3:0]          instr_code;
   logic [DATA_W-1:0]   instr_a;
   logic [DATA_W-1:0]   instr_b;
   logic [DATA_W-1:0]   A;
   logic [DATA_W-1:0]   B;
   logic [OPCODE_W-1:0] opcode;
   logic                alu_busy;
   logic                done;
   logic                illegal;
   logic [7:0]          instr_count;

   modport master (
      output instr_valid, instr_code, instr_a, instr_b,
      input  instr_ready, A, B, opcode, alu_busy, done, illegal, instr_count
   );

   modport slave (
      input  instr_valid, instr_code, instr_a, instr_b,
      output instr_ready, A, B, opcode, alu_busy, done, illegal, instr_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one instruction at a time into the ALU: operands first, then a one-hot
// opcode for EXEC_CYCLES cycles, then back to zero so repeated ops re-evaluate.
//
//   state     | meaning
//   S_IDLE    | instr_ready high, waiting for a handshake
//   S_LOAD    | operands on A/B, opcode still 0 so they settle first
//   S_DECODE  | classify code; illegal codes skip execution
//   S_EXECUTE | opcode one-hot, dwell set by down-counter
//   S_RETIRE  | opcode 0, done pulse, instr_count advanced
module alu_op_sequencer #(
   parameter int DATA_W      = 8,
   parameter int OPCODE_W    = 16,
   parameter int EXEC_CYCLES = 2
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_sequencer_if.slave bus
);

   localparam int EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
   localparam int CNT_W    = (EXEC_EFF > 1) ? $clog2(EXEC_EFF) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DECODE,
      S_EXECUTE,
      S_RETIRE
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [3:0]          code_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [OPCODE_W-1:0] opcode_dec;
   logic                accept;

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      opcode_dec = '0;
      opcode_dec[code_q[2:0]] = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid && bus.instr_ready) begin
               accept  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD:    state_d = S_DECODE;
         S_DECODE:  state_d = code_q[3] ? S_RETIRE : S_EXECUTE;
         S_EXECUTE: begin
            if (cnt_q == '0) begin
               state_d = S_RETIRE;
            end
         end
         S_RETIRE:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         code_q          <= '0;
         cnt_q           <= '0;
         bus.instr_ready <= 1'b0;
         bus.A           <= '0;
         bus.B           <= '0;
         bus.opcode      <= '0;
         bus.alu_busy    <= 1'b0;
         bus.done        <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.instr_count <= '0;
      end else begin
         state_q         <= state_d;
         bus.instr_ready <= (state_d == S_IDLE);
         // Operands are captured on the handshake edge so they are already stable in LOAD.
         if (accept) begin
            code_q <= bus.instr_code;
            bus.A  <= bus.instr_a[DATA_W-1:0];
            bus.B  <= bus.instr_b[DATA_W-1:0];
         end
         if (state_q == S_DECODE) begin
            cnt_q <= CNT_W'(EXEC_EFF - 1);
         end else if (state_q == S_EXECUTE && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         bus.opcode   <= (state_d == S_EXECUTE) ? opcode_dec : '0;
         bus.alu_busy <= (state_d == S_EXECUTE);
         bus.done     <= (state_d == S_RETIRE);
         bus.illegal  <= (state_d == S_RETIRE) && code_q[3];
         if (state_d == S_RETIRE) begin
            bus.instr_count <= bus.instr_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: timeline model of each instruction, directed cases, random traffic.
module tb_alu_op_sequencer;

   localparam int EC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if bus  ();
   alu_op_sequencer_if bus1 ();
   alu_op_sequencer_if bus2 ();

   alu_op_sequencer #(.EXEC_CYCLES(EC)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   alu_op_sequencer #(.EXEC_CYCLES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   alu_op_sequencer #(.EXEC_CYCLES(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: k counts cycles since the accepting edge (-1 when idle).
   int         k;
   bit         m_rdy;
   logic [3:0] m_code;
   logic [7:0] m_a, m_b, m_cnt;

   function automatic int kret();
      return (m_code >= 4'd8) ? 2 : 2 + EC;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = -1; m_rdy = 1'b0; m_code = '0; m_a = '0; m_b = '0; m_cnt = '0;
      end else if (k < 0) begin
         if (m_rdy && bus.instr_valid) begin
            k = 0; m_code = bus.instr_code; m_a = bus.instr_a; m_b = bus.instr_b;
         end else begin
            m_rdy = 1'b1;
         end
      end else begin
         k = k + 1;
         if (k == kret()) m_cnt = m_cnt + 8'd1;
         else if (k > kret()) k = -1;
      end
   end

   logic [15:0] e_op;
   logic        e_done;
   always @(negedge clk) begin
      if (chk_en) begin
         e_op   = (k >= 2 && k < 2 + EC && m_code < 4'd8) ? (16'h1 << m_code) : 16'h0;
         e_done = (k >= 0) && (k == kret());
         chk("m_ready",   bus.instr_ready, (k < 0) && m_rdy);
         chk("m_A",       bus.A, m_a);
         chk("m_B",       bus.B, m_b);
         chk("m_opcode",  bus.opcode, e_op);
         chk("m_busy",    bus.alu_busy, e_op != 16'h0);
         chk("m_done",    bus.done, e_done);
         chk("m_illegal", bus.illegal, e_done && m_code >= 4'd8);
         chk("m_count",   bus.instr_count, m_cnt);
      end
   end

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.instr_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_ready: instr_ready stayed low, required 1 at %0t", $time);
      end
   endtask

   task automatic issue(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b);
      wait_ready();
      bus.instr_valid = 1'b1; bus.instr_code = code; bus.instr_a = a; bus.instr_b = b;
      @(negedge clk);
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   int          d1, d2, ndone;
   logic [15:0] t3_op  [12];
   logic [15:0] t3_exp [12];

   initial begin
      t3_exp = '{16'h0, 16'h0, 16'h2, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2, 16'h2, 16'h0, 16'h0};
      bus.instr_valid = 0;  bus.instr_code = 0;  bus.instr_a = 0;  bus.instr_b = 0;
      bus1.instr_valid = 0; bus1.instr_code = 0; bus1.instr_a = 0; bus1.instr_b = 0;
      bus2.instr_valid = 0; bus2.instr_code = 0; bus2.instr_a = 0; bus2.instr_b = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready",  bus.instr_ready, 0);
      chk("rst_opcode", bus.opcode, 0);
      chk("rst_count",  bus.instr_count, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("ready_after_release", bus.instr_ready, 1);

      // ADD on all three instances: dwell of 2, 1 and 4 cycles
      bus.instr_valid = 1;  bus.instr_code = 0;  bus.instr_a = 8'h05;  bus.instr_b = 8'h07;
      bus1.instr_valid = 1; bus1.instr_code = 0; bus1.instr_a = 8'h05; bus1.instr_b = 8'h07;
      bus2.instr_valid = 1; bus2.instr_code = 0; bus2.instr_a = 8'h05; bus2.instr_b = 8'h07;
      d1 = -1; d2 = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.instr_valid = 0; bus1.instr_valid = 0; bus2.instr_valid = 0;
            chk("t2_A", bus.A, 8'h05);
            chk("t2_B", bus.B, 8'h07);
            chk("t2_op_load", bus.opcode, 16'h0);
         end
         if (c == 2 || c == 3) chk("t2_op_exec", bus.opcode, 16'h0001);
         if (c == 4) begin
            chk("t2_done", bus.done, 1);
            chk("t2_illegal", bus.illegal, 0);
            chk("t2_count", bus.instr_count, 8'd1);
         end
         if (bus1.done && d1 < 0) d1 = c;
         if (bus2.done && d2 < 0) d2 = c;
      end
      chk("t6_done_ec1", d1, 3);
      chk("t6_done_ec4", d2, 6);

      // Back-to-back SUB with valid held high
      wait_ready();
      bus.instr_valid = 1; bus.instr_code = 1; bus.instr_a = 8'h40; bus.instr_b = 8'h01;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         t3_op[c] = bus.opcode;
         if (bus.done) ndone++;
         if (c == 6) bus.instr_valid = 0;
      end
      for (int c = 0; c < 12; c++) chk($sformatf("t3_op_c%0d", c), t3_op[c], t3_exp[c]);
      chk("t3_ndone", ndone, 2);
      chk("t3_count", bus.instr_count, 8'd3);

      // Illegal code retires straight after DECODE
      wait_ready();
      bus.instr_valid = 1; bus.instr_code = 4'hA; bus.instr_a = 8'h12; bus.instr_b = 8'h34;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) bus.instr_valid = 0;
         chk("t4_op", bus.opcode, 16'h0);
         if (c == 2) begin
            chk("t4_done", bus.done, 1);
            chk("t4_illegal", bus.illegal, 1);
            chk("t4_count", bus.instr_count, 8'd4);
         end
         if (c == 3) chk("t4_illegal_clr", bus.illegal, 0);
      end

      // New instruction offered while busy is held until instr_ready returns
      wait_ready();
      bus.instr_valid = 1; bus.instr_code = 0; bus.instr_a = 8'h11; bus.instr_b = 8'h22;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 0) bus.instr_valid = 0;
         if (c == 2) begin
            bus.instr_valid = 1; bus.instr_code = 3; bus.instr_a = 8'hFF; bus.instr_b = 8'h01;
         end
         if (c >= 3 && c <= 5) chk("t5_A_hold", bus.A, 8'h11);
         if (c == 6) begin
            chk("t5_A_new", bus.A, 8'hFF);
            chk("t5_B_new", bus.B, 8'h01);
            bus.instr_valid = 0;
         end
      end

      // Reset in the middle of EXECUTE
      issue(4'd0, 8'h33, 8'h44);
      @(negedge clk);
      @(negedge clk);
      chk("t1_op_exec", bus.opcode, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_opcode", bus.opcode, 16'h0);
      chk("t1_A", bus.A, 8'h0);
      chk("t1_B", bus.B, 8'h0);
      chk("t1_count", bus.instr_count, 8'h0);
      chk("t1_ready", bus.instr_ready, 0);
      chk("t1_busy", bus.alu_busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("t1_ready_pre", bus.instr_ready, 0);
      @(negedge clk);
      chk("t1_ready_post", bus.instr_ready, 1);

      // 256 retirements wrap instr_count
      for (int i = 0; i < 256; i++) begin
         issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
         if (i == 254) begin
            wait_ready();
            chk("t6_count_ff", bus.instr_count, 8'hFF);
         end
      end
      wait_ready();
      chk("t6_count_wrap", bus.instr_count, 8'h00);

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         bus.instr_valid = ($urandom_range(0, 3) != 0);
         bus.instr_code  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 7));
         bus.instr_a     = 8'($urandom);
         bus.instr_b     = 8'($urandom);
      end
      bus.instr_valid = 0;
      repeat (10) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
